// File: rtl/debounce_edge.sv
// debounce_edge: synchronizes and debounces a raw input,
// producing a clean level plus rise/fall/any-edge/glitch strobes.
module debounce_edge #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter bit          INIT_LEVEL      = 1'b0
) (
   input  logic clk,
   input  logic nrst,
   input  logic in,
   output logic out_level,
   output logic rise,
   output logic fall,
   output logic any_edge,
   output logic glitch
);

   localparam int unsigned CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam int unsigned LAST_I =
      (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
   localparam logic [CW-1:0] LAST = CW'(LAST_I);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [0:0] {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nxt;
   logic                   r_level;
   logic                   w_level_nxt;
   logic                   r_rise;
   logic                   r_fall;
   logic                   r_any;
   logic                   r_glitch;
   logic                   w_glitch_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;
   logic                   w_s;
   logic                   w_diff;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_diff = (w_s != r_level);

   // Synchronizer chain bringing the raw input into the clk domain
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sync <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in};
      end
   end

   // Next-state, counter and level decision; strobes derive from level change
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_level_nxt  = r_level;
      w_glitch_nxt = 1'b0;
      if (DEBOUNCE_CYCLES == 0) begin
         w_state_nxt = STABLE;
         w_cnt_nxt   = '0;
         w_level_nxt = w_s;
      end else begin
         unique case (r_state)
            STABLE: begin
               if (w_diff) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     w_level_nxt = w_s;
                  end else begin
                     w_state_nxt = CHECK;
                     w_cnt_nxt   = ONE;
                  end
               end
            end
            CHECK: begin
               if (w_diff) begin
                  if (r_cnt == LAST) begin
                     w_level_nxt = w_s;
                     w_cnt_nxt   = '0;
                     w_state_nxt = STABLE;
                  end else begin
                     w_cnt_nxt = r_cnt + ONE;
                  end
               end else begin
                  w_cnt_nxt    = '0;
                  w_state_nxt  = STABLE;
                  w_glitch_nxt = 1'b1;
               end
            end
         endcase
      end
      w_rise_nxt = w_level_nxt & ~r_level;
      w_fall_nxt = ~w_level_nxt & r_level;
   end

   // State, counter, level and registered strobes
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state  <= STABLE;
         r_cnt    <= '0;
         r_level  <= INIT_LEVEL;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_any    <= 1'b0;
         r_glitch <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_level  <= w_level_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_any    <= w_rise_nxt | w_fall_nxt;
         r_glitch <= w_glitch_nxt;
      end
   end

   assign out_level = r_level;
   assign rise      = r_rise;
   assign fall      = r_fall;
   assign any_edge  = r_any;
   assign glitch    = r_glitch;

endmodule
